// File: rtl/alu_reg_sequencer.sv
// alu_reg_sequencer
// Command-driven controller that sequences an external W-bit ALU and a multi-function
// register as an accumulator datapath. It accepts one command at a time and issues exactly
// one register strobe per cycle. MUL is a fixed-length Horner shift-add (1 + 2W strobe
// cycles). The new accumulator value is returned over a valid/ready response channel.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmd_valid/ready          command handshake; cmd_op, cmd_oc, cmd_data carry the command
//   rsp_valid/ready          response handshake; rsp_data is the accumulator after the command
//   busy                     high whenever the controller is not idle
//   alu_oc, alu_a, alu_b     ALU operands; alu_f is the ALU result
//   reg_cl..reg_il, reg_in   register controls and parallel-load data; reg_out is the accumulator
module alu_reg_sequencer #(
    parameter int unsigned W      = 4,
    parameter logic [2:0]  OC_ADD = 3'b000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [2:0]   cmd_oc,
    input  logic [W-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         busy,
    output logic [2:0]   alu_oc,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_f,
    output logic         reg_cl,
    output logic         reg_ld,
    output logic         reg_inc,
    output logic         reg_dec,
    output logic         reg_sr,
    output logic         reg_ir,
    output logic         reg_sl,
    output logic         reg_il,
    output logic [W-1:0] reg_in,
    input  logic [W-1:0] reg_out
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] OpMul  = 3'd0;
    localparam logic [2:0] OpClr  = 3'd1;
    localparam logic [2:0] OpLoad = 3'd2;
    localparam logic [2:0] OpInc  = 3'd3;
    localparam logic [2:0] OpDec  = 3'd4;
    localparam logic [2:0] OpShl  = 3'd5;
    localparam logic [2:0] OpShr  = 3'd6;
    localparam logic [2:0] OpAlu  = 3'd7;

    typedef enum logic [2:0] {StIdle, StExec, StMclr, StMshl, StMadd, StResp} state_e;

    state_e          state_q;
    logic [W-1:0]    data_q;
    logic [W-1:0]    m_q;
    logic [CW-1:0]   bit_q;

    // Registered strobes/selects: each is set on the edge that enters the state it belongs to,
    // so they are high for exactly that state's cycle.
    logic            cl_q, ld_q, inc_q, dec_q, sr_q, sl_q, ir_q, il_q;
    logic [2:0]      alu_oc_q;
    logic [W-1:0]    alu_b_q;
    logic [W-1:0]    in_data_q;
    logic            a_from_acc_q;
    logic            in_from_alu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            data_q        <= '0;
            m_q           <= '0;
            bit_q         <= '0;
            cl_q          <= 1'b0;
            ld_q          <= 1'b0;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            sr_q          <= 1'b0;
            sl_q          <= 1'b0;
            ir_q          <= 1'b0;
            il_q          <= 1'b0;
            alu_oc_q      <= '0;
            alu_b_q       <= '0;
            in_data_q     <= '0;
            a_from_acc_q  <= 1'b0;
            in_from_alu_q <= 1'b0;
        end else begin
            cl_q          <= 1'b0;
            ld_q          <= 1'b0;
            inc_q         <= 1'b0;
            dec_q         <= 1'b0;
            sr_q          <= 1'b0;
            sl_q          <= 1'b0;
            ir_q          <= 1'b0;
            il_q          <= 1'b0;
            alu_oc_q      <= '0;
            alu_b_q       <= '0;
            in_data_q     <= '0;
            a_from_acc_q  <= 1'b0;
            in_from_alu_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        data_q <= cmd_data;
                        m_q    <= reg_out;
                        if (cmd_op == OpMul) begin
                            state_q <= StMclr;
                            cl_q    <= 1'b1;
                            bit_q   <= CW'(W - 1);
                        end else begin
                            state_q <= StExec;
                            case (cmd_op)
                                OpClr:  cl_q <= 1'b1;
                                OpLoad: begin
                                    ld_q      <= 1'b1;
                                    in_data_q <= cmd_data;
                                end
                                OpInc:  inc_q <= 1'b1;
                                OpDec:  dec_q <= 1'b1;
                                OpShl:  begin
                                    sl_q <= 1'b1;
                                    il_q <= cmd_data[0];
                                end
                                OpShr:  begin
                                    sr_q <= 1'b1;
                                    ir_q <= cmd_data[0];
                                end
                                OpAlu:  begin
                                    ld_q          <= 1'b1;
                                    alu_oc_q      <= cmd_oc;
                                    alu_b_q       <= cmd_data;
                                    a_from_acc_q  <= 1'b1;
                                    in_from_alu_q <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StExec: state_q <= StResp;
                StMclr: begin
                    state_q <= StMshl;
                    sl_q    <= 1'b1;
                end
                StMshl: begin
                    // acc <= 2*acc + (data[i] ? M : 0), MSB first
                    state_q       <= StMadd;
                    ld_q          <= 1'b1;
                    alu_oc_q      <= OC_ADD;
                    alu_b_q       <= data_q[bit_q] ? m_q : '0;
                    a_from_acc_q  <= 1'b1;
                    in_from_alu_q <= 1'b1;
                end
                StMadd: begin
                    if (bit_q == '0) begin
                        state_q <= StResp;
                    end else begin
                        bit_q   <= bit_q - CW'(1);
                        state_q <= StMshl;
                        sl_q    <= 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle) && !rst;
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    // No strobes fire in RESP, so reg_out is stable while the response is held.
    assign rsp_data  = (state_q == StResp) ? reg_out : '0;

    assign reg_cl  = cl_q;
    assign reg_ld  = ld_q;
    assign reg_inc = inc_q;
    assign reg_dec = dec_q;
    assign reg_sr  = sr_q;
    assign reg_ir  = ir_q;
    assign reg_sl  = sl_q;
    assign reg_il  = il_q;
    assign alu_oc  = alu_oc_q;
    assign alu_a   = a_from_acc_q ? reg_out : '0;
    assign alu_b   = alu_b_q;
    assign reg_in  = in_from_alu_q ? alu_f : in_data_q;

endmodule
